// File: rtl/seven_led_pkg.sv
// Constants and types shared by the binary-to-BCD converter and the seven_led display path.
package seven_led_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4;
  localparam int HEX_W      = 7;
  localparam logic [26:0] MAX_DEC = 27'd99_999_999;

  typedef enum logic {IDLE, CONV} state_t;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the IO register (master) and the BCD converter (slave).
interface bin_to_bcd_seq_if #(parameter int DATA_W = 27);
  import seven_led_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              o_ovf;
  logic [HEX_W-1:0]  o_hex0_o, o_hex1_o, o_hex2_o, o_hex3_o;
  logic [HEX_W-1:0]  o_hex4_o, o_hex5_o, o_hex6_o, o_hex7_o;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_valid, o_ovf,
    input  o_hex0_o, o_hex1_o, o_hex2_o, o_hex3_o,
    input  o_hex4_o, o_hex5_o, o_hex6_o, o_hex7_o
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_valid, o_ovf,
    output o_hex0_o, o_hex1_o, o_hex2_o, o_hex3_o,
    output o_hex4_o, o_hex5_o, o_hex6_o, o_hex7_o
  );
endinterface

// File: rtl/dd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more before it is shifted.
module dd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one iteration per clock, results held in
// output registers so the displays never see partial digits.
module bin_to_bcd_seq
  import seven_led_pkg::*;
#(
  parameter int DATA_W = 27
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t                               state;
  logic [DATA_W-1:0]                    bin_q, bin_nxt;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]     bcd_q, bcd_adj, bcd_nxt, hex_q;
  logic [CNT_W-1:0]                     cnt;
  logic                                 ovf_pend, ovf_q, ready_q, valid_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    dd_digit_adj u_adj (.din(bcd_q[g]), .dout(bcd_adj[g]));
  end

  // Adjust on the pre-shift digits, then shift the whole {bcd, bin} word left.
  assign {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      hex_q    <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            // Out-of-range values saturate so every digit stays within 0..9.
            if (bus.i_data > DATA_W'(MAX_DEC)) begin
              bin_q    <= DATA_W'(MAX_DEC);
              ovf_pend <= 1'b1;
            end else begin
              bin_q    <= bus.i_data;
              ovf_pend <= 1'b0;
            end
            bcd_q   <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_nxt;
          bin_q <= bin_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            hex_q   <= bcd_nxt;
            ovf_q   <= ovf_pend;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_hex0_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[0]};
  assign bus.o_hex1_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[1]};
  assign bus.o_hex2_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[2]};
  assign bus.o_hex3_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[3]};
  assign bus.o_hex4_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[4]};
  assign bus.o_hex5_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[5]};
  assign bus.o_hex6_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[6]};
  assign bus.o_hex7_o = {{(HEX_W-BCD_W){1'b0}}, hex_q[7]};
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table plus hand-written handshake and reset sequences.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.DATA_W(27)) bus ();
  bin_to_bcd_seq #(.DATA_W(27)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    logic [26:0] data;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [55:0] hex_of(input logic [31:0] bcd);
    logic [55:0] r;
    r = '0;
    for (int d = 0; d < 8; d++) r[d*7 +: 7] = {3'b000, bcd[d*4 +: 4]};
    return r;
  endfunction

  function automatic logic [55:0] hex_now();
    return {bus.o_hex7_o, bus.o_hex6_o, bus.o_hex5_o, bus.o_hex4_o,
            bus.o_hex3_o, bus.o_hex2_o, bus.o_hex1_o, bus.o_hex0_o};
  endfunction

  // Issue one request and follow it to its o_valid pulse. inj_at>0 pulses a
  // stray request (555) in that cycle of the conversion. Returns in the o_valid cycle.
  task automatic convert(input string name, input logic [26:0] data,
                         input logic [31:0] bcd, input logic ovf, input int inj_at);
    int lat;
    int ready_bad;
    bit seen;
    for (int i = 0; i < 40 && !bus.o_ready; i++) step();
    chk({name, "_ready_wait"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = data;
    step();
    bus.i_valid = 1'b0;
    bus.i_data  = 27'd0;
    lat = 1;
    ready_bad = 0;
    seen = 1'b0;
    while (lat < 45 && !seen) begin
      if (inj_at > 0 && lat == inj_at) begin
        bus.i_valid = 1'b1;
        bus.i_data  = 27'd555;
      end else begin
        bus.i_valid = 1'b0;
      end
      if (bus.o_ready) ready_bad++;
      step();
      lat++;
      seen = bus.o_valid;
    end
    bus.i_valid = 1'b0;
    chk({name, "_seen"},    64'(seen), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'd28);
    chk({name, "_busy"},    64'(ready_bad), 64'd0);
    chk({name, "_digits"},  64'(hex_now()), 64'(hex_of(bcd)));
    chk({name, "_ovf"},     64'(bus.o_ovf), 64'(ovf));
    chk({name, "_rdy_vld"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{27'd0,          32'h0000_0000, 1'b0};
    vecs[1] = '{27'd12_345_678, 32'h1234_5678, 1'b0};
    vecs[2] = '{27'd99_999_999, 32'h9999_9999, 1'b0};
    vecs[3] = '{27'd100_000_000,32'h9999_9999, 1'b1};
    vecs[4] = '{27'h7FF_FFFF,   32'h9999_9999, 1'b1};
    vecs[5] = '{27'd5,          32'h0000_0005, 1'b0};

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 27'd0;
    repeat (3) step();
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_ovf",   64'(bus.o_ovf),   64'd0);
    chk("rst_hex",   64'(hex_now()),   64'd0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      convert($sformatf("vec%0d", v), vecs[v].data, vecs[v].bcd, vecs[v].ovf, 0);
      step();
      chk($sformatf("vec%0d_pulse_end", v), 64'(bus.o_valid), 64'd0);
      chk($sformatf("vec%0d_hold", v), 64'(hex_now()), 64'(hex_of(vecs[v].bcd)));
    end

    // Stray request during conversion must be dropped, not queued.
    convert("ignore", 27'd907, 32'h0000_0907, 1'b0, 6);
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (bus.o_valid) pulses++;
    end
    chk("ignore_no_extra", 64'(pulses), 64'd0);
    chk("ignore_hold", 64'(hex_now()), 64'(hex_of(32'h0000_0907)));

    // Back-to-back: second request lands on the edge that ends the first pulse.
    convert("b2b_first",  27'd42,         32'h0000_0042, 1'b0, 0);
    convert("b2b_second", 27'd31_415_926, 32'h3141_5926, 1'b0, 0);
    step();

    // Reset in the middle of a conversion aborts it and clears the outputs.
    bus.i_valid = 1'b1;
    bus.i_data  = 27'd88_888_888;
    step();
    bus.i_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_hex",   64'(hex_now()),   64'd0);
    chk("abort_ovf",   64'(bus.o_ovf),   64'd0);
    chk("abort_ready", 64'(bus.o_ready), 64'd1);
    chk("abort_valid", 64'(bus.o_valid), 64'd0);
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (bus.o_valid) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);

    // Reset wins over a simultaneous request.
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 27'd5;
    step();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    chk("rst_win_ready", 64'(bus.o_ready), 64'd1);
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (bus.o_valid) pulses++;
    end
    chk("rst_win_no_pulse", 64'(pulses), 64'd0);

    // A fresh request after all that still converts correctly.
    convert("after", 27'd70_000_001, 32'h7000_0001, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
